parity_arbiter: RTL

Round-robin arbiter that shares one parity-generation datapath among `NumReq` requesters. Each requester offers a `Width`-bit word over a valid/ready handshake. The block grants one requester per cycle, computes the word's parity, and holds the result in a single output register until the consumer accepts it. It sits between several producer blocks and a common parity consumer, so the design carries only one parity tree.

---
 rtl/parity_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/parity_arbiter.sv
// Round-robin arbiter sharing one parity tree among NumReq valid/ready requesters.
// One result register holds the granted word, its index and parity until consumed.
module parity_arbiter #(
  parameter  int Width  = 16,
  parameter  int NumReq = 4,
  localparam int IdW    = $clog2(NumReq)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_odd,
  input  logic [NumReq-1:0]       req_valid,
  input  logic [NumReq*Width-1:0] req_data,
  output logic [NumReq-1:0]       req_ready,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [IdW-1:0]          res_id,
  output logic [Width-1:0]        res_data,
  output logic                    res_parity,
  output logic [15:0]             grant_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [IdW-1:0]   r_ptr;
  logic [IdW-1:0]   r_id;
  logic [Width-1:0] r_data;
  logic             r_parity;
  logic [15:0]      r_grant_cnt;

  logic [IdW-1:0]   w_grant;
  logic [IdW-1:0]   w_idx;
  logic             w_grant_vld;
  logic             w_can_accept;
  logic             w_xfer;
  logic [Width-1:0] w_word;

  // Scan from the highest offset down so the lowest offset from r_ptr wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_grant_vld = 1'b0;
    w_grant     = '0;
    w_idx       = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      w_idx = IdW'((int'(r_ptr) + i) % NumReq);
      if (req_valid[w_idx]) begin
        w_grant_vld = 1'b1;
        w_grant     = w_idx;
      end
    end
  end

  assign w_can_accept = (r_state == EMPTY) || res_ready;
  assign w_xfer       = w_grant_vld && w_can_accept && !rst;
  assign w_word       = req_data[w_grant*Width +: Width];

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) r_state <= EMPTY;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (w_xfer) w_state_nxt = FULL;
      FULL:    if (w_xfer) w_state_nxt = FULL;
               else if (res_ready) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  // Result payload, priority pointer and transfer counter move only on a transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_id        <= '0;
      r_data      <= '0;
      r_parity    <= 1'b0;
      r_grant_cnt <= '0;
    end else if (w_xfer) begin
      r_ptr       <= (w_grant == IdW'(NumReq - 1)) ? '0 : w_grant + 1'b1;
      r_id        <= w_grant;
      r_data      <= w_word;
      r_parity    <= (^w_word) ^ cfg_odd;
      r_grant_cnt <= r_grant_cnt + 16'd1;
    end
  end

  // Output logic.
  always_comb begin
    req_ready = '0;
    if (w_xfer) req_ready[w_grant] = 1'b1;
  end

  assign res_valid  = (r_state == FULL);
  assign res_id     = r_id;
  assign res_data   = r_data;
  assign res_parity = r_parity;
  assign grant_cnt  = r_grant_cnt;

endmodule
